// File: rtl/joltage_bank_max.sv
// ---------------------------------------------------------------------------
// joltage_bank_max
//
// Streaming solver for the battery-bank joltage puzzle. It consumes one
// decoded character per cycle. For each line of digits it keeps, for every
// length j in 1..PICK_COUNT, the largest j-digit number formed from that
// line's digits taken in order. On LF or EOT it adds the PICK_COUNT-digit
// maximum to a running sum. EOT freezes the total until the next digit
// starts a new puzzle.
//
// Parameters
//   PICK_COUNT  digits picked per bank (1..12)
//   VAL_W       width of each per-line candidate, must hold 10^PICK_COUNT-1
//   ACC_W       width of the running sum
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   char_valid       a character is present this cycle
//   digit_in         decoded digit value 0..9
//   digit_valid      the character is an ASCII digit
//   line_feed        the character is LF
//   end_of_puzzle_tx the character is EOT
//   result           running / final sum (qualify with result_valid)
//   result_valid     level, high once EOT has been folded
//   line_count       lines that contributed to result, saturating
//   overflow         sticky carry-out of the sum
// ---------------------------------------------------------------------------
module joltage_bank_max #(
    parameter int PICK_COUNT = 2,
    parameter int VAL_W      = 40,
    parameter int ACC_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             char_valid,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    input  logic             line_feed,
    input  logic             end_of_puzzle_tx,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    output logic [15:0]      line_count,
    output logic             overflow
);

    localparam int DC_W = $clog2(PICK_COUNT + 1);
    localparam logic [DC_W-1:0] DC_FULL = DC_W'(PICK_COUNT);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // Multiply by ten using two shifts and an add, truncated to VAL_W.
    function automatic logic [VAL_W-1:0] times_ten(input logic [VAL_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    state_t            state_r, state_next_s;
    // Element 0 is the constant "empty prefix" and is held at zero.
    logic [VAL_W-1:0]  best_r      [0:PICK_COUNT];
    logic [VAL_W-1:0]  best_next_s [0:PICK_COUNT];
    logic [VAL_W-1:0]  cand_s      [0:PICK_COUNT];
    logic [DC_W-1:0]   dcount_r, dcount_next_s;
    logic [ACC_W-1:0]  sum_r, sum_next_s;
    logic [15:0]       line_count_r, line_count_next_s;
    logic              overflow_r, overflow_next_s;
    logic              result_valid_r, result_valid_next_s;

    logic              is_eot_s, is_lf_s, is_digit_s;
    logic              line_full_s;
    logic [ACC_W:0]    add_s;
    logic [15:0]       line_count_inc_s;

    // Character classification with EOT > LF > digit priority.
    always_comb begin
        is_eot_s   = char_valid & end_of_puzzle_tx;
        is_lf_s    = char_valid & ~end_of_puzzle_tx & line_feed;
        is_digit_s = char_valid & ~end_of_puzzle_tx & ~line_feed & digit_valid;
    end

    // Fold arithmetic: the line contributes only when it reached PICK_COUNT digits.
    always_comb begin
        line_full_s      = (dcount_r == DC_FULL);
        add_s            = {1'b0, sum_r} + {1'b0, ACC_W'(best_r[PICK_COUNT])};
        line_count_inc_s = (line_count_r == 16'hFFFF) ? 16'hFFFF : (line_count_r + 16'd1);
    end

    // Candidate for length j: best of length j-1 with the new digit appended.
    always_comb begin
        cand_s[0] = '0;
        for (int j = 1; j <= PICK_COUNT; j++) begin
            cand_s[j] = times_ten(best_r[j-1]) + VAL_W'(digit_in);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next_s        = state_r;
        dcount_next_s       = dcount_r;
        sum_next_s          = sum_r;
        line_count_next_s   = line_count_r;
        overflow_next_s     = overflow_r;
        result_valid_next_s = result_valid_r;
        for (int j = 0; j <= PICK_COUNT; j++) begin
            best_next_s[j] = best_r[j];
        end

        case (state_r)
            ST_ACCUM: begin
                if (is_eot_s || is_lf_s) begin
                    if (line_full_s) begin
                        sum_next_s        = add_s[ACC_W-1:0];
                        line_count_next_s = line_count_inc_s;
                        overflow_next_s   = overflow_r | add_s[ACC_W];
                    end else begin
                        sum_next_s        = sum_r;
                    end
                    for (int j = 0; j <= PICK_COUNT; j++) begin
                        best_next_s[j] = '0;
                    end
                    dcount_next_s = '0;
                    if (is_eot_s) begin
                        state_next_s        = ST_DONE;
                        result_valid_next_s = 1'b1;
                    end else begin
                        state_next_s        = ST_ACCUM;
                    end
                end else if (is_digit_s) begin
                    // Only lengths reachable with one more digit are updated;
                    // all lengths read pre-update values.
                    for (int j = 1; j <= PICK_COUNT; j++) begin
                        if ((int'(dcount_r) + 1 >= j) && (cand_s[j] > best_r[j])) begin
                            best_next_s[j] = cand_s[j];
                        end else begin
                            best_next_s[j] = best_r[j];
                        end
                    end
                    dcount_next_s = line_full_s ? DC_FULL : (dcount_r + DC_W'(1));
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (is_digit_s) begin
                    // New puzzle: best/dcount were already cleared by the EOT
                    // fold, so the digit is the first one of a fresh line.
                    sum_next_s          = '0;
                    line_count_next_s   = 16'd0;
                    overflow_next_s     = 1'b0;
                    result_valid_next_s = 1'b0;
                    state_next_s        = ST_ACCUM;
                    for (int j = 1; j <= PICK_COUNT; j++) begin
                        if ((int'(dcount_r) + 1 >= j) && (cand_s[j] > best_r[j])) begin
                            best_next_s[j] = cand_s[j];
                        end else begin
                            best_next_s[j] = best_r[j];
                        end
                    end
                    dcount_next_s = line_full_s ? DC_FULL : (dcount_r + DC_W'(1));
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s        = ST_ACCUM;
                result_valid_next_s = 1'b0;
            end
        endcase
        best_next_s[0] = '0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_ACCUM;
            dcount_r       <= '0;
            sum_r          <= '0;
            line_count_r   <= 16'd0;
            overflow_r     <= 1'b0;
            result_valid_r <= 1'b0;
            for (int j = 0; j <= PICK_COUNT; j++) begin
                best_r[j] <= '0;
            end
        end else begin
            state_r        <= state_next_s;
            dcount_r       <= dcount_next_s;
            sum_r          <= sum_next_s;
            line_count_r   <= line_count_next_s;
            overflow_r     <= overflow_next_s;
            result_valid_r <= result_valid_next_s;
            for (int j = 0; j <= PICK_COUNT; j++) begin
                best_r[j] <= best_next_s[j];
            end
        end
    end

    assign result       = sum_r;
    assign result_valid = result_valid_r;
    assign line_count   = line_count_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_joltage_bank_max.sv
// ---------------------------------------------------------------------------
// tb_joltage_bank_max
//
// Drives one character stream into three configurations of joltage_bank_max:
//   inst 0: PICK_COUNT=2,  ACC_W=64
//   inst 1: PICK_COUNT=12, ACC_W=64
//   inst 2: PICK_COUNT=2,  ACC_W=8 (wrapping sum)
// Expected outputs are pushed to a scoreboard queue as each character is
// issued and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_joltage_bank_max;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        char_valid;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        line_feed;
    logic        end_of_puzzle_tx;

    logic [63:0] r2, r12;
    logic [7:0]  r8;
    logic        v2, v12, v8;
    logic [15:0] lc2, lc12, lc8;
    logic        o2, o12, o8;

    always #5 clk = ~clk;

    joltage_bank_max #(.PICK_COUNT(2), .VAL_W(40), .ACC_W(64)) u_p2 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .digit_in(digit_in),
        .digit_valid(digit_valid), .line_feed(line_feed),
        .end_of_puzzle_tx(end_of_puzzle_tx), .result(r2), .result_valid(v2),
        .line_count(lc2), .overflow(o2));

    joltage_bank_max #(.PICK_COUNT(12), .VAL_W(40), .ACC_W(64)) u_p12 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .digit_in(digit_in),
        .digit_valid(digit_valid), .line_feed(line_feed),
        .end_of_puzzle_tx(end_of_puzzle_tx), .result(r12), .result_valid(v12),
        .line_count(lc12), .overflow(o12));

    joltage_bank_max #(.PICK_COUNT(2), .VAL_W(40), .ACC_W(8)) u_a8 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .digit_in(digit_in),
        .digit_valid(digit_valid), .line_feed(line_feed),
        .end_of_puzzle_tx(end_of_puzzle_tx), .result(r8), .result_valid(v8),
        .line_count(lc8), .overflow(o8));

    typedef struct {
        string       tag;
        int          inst;
        logic [63:0] res;
        logic [15:0] lc;
        logic        vld;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   check_cnt = 0;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        check_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Compare every queued expectation against the current DUT outputs.
    task automatic check_sb();
        exp_t        e;
        logic [63:0] o_res;
        logic [15:0] o_lc;
        logic        o_vld, o_ovf;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.inst)
                0:       begin o_res = r2;            o_lc = lc2;  o_vld = v2;  o_ovf = o2;  end
                1:       begin o_res = r12;           o_lc = lc12; o_vld = v12; o_ovf = o12; end
                default: begin o_res = {56'd0, r8};   o_lc = lc8;  o_vld = v8;  o_ovf = o8;  end
            endcase
            cmp($sformatf("%s/i%0d result", e.tag, e.inst), o_res, e.res);
            cmp($sformatf("%s/i%0d line_count", e.tag, e.inst), {48'd0, o_lc}, {48'd0, e.lc});
            cmp($sformatf("%s/i%0d result_valid", e.tag, e.inst), {63'd0, o_vld}, {63'd0, e.vld});
            cmp($sformatf("%s/i%0d overflow", e.tag, e.inst), {63'd0, o_ovf}, {63'd0, e.ovf});
        end
    endtask

    task automatic expect3(input string tag,
                           input logic [63:0] r2e,  input logic [15:0] l2e,
                           input logic [63:0] r12e, input logic [15:0] l12e,
                           input logic [63:0] r8e,  input logic [15:0] l8e,
                           input logic vld, input logic ovf8);
        exp_t e;
        e.tag = tag; e.vld = vld;
        e.inst = 0; e.res = r2e;  e.lc = l2e;  e.ovf = 1'b0; sbq.push_back(e);
        e.inst = 1; e.res = r12e; e.lc = l12e; e.ovf = 1'b0; sbq.push_back(e);
        e.inst = 2; e.res = r8e;  e.lc = l8e;  e.ovf = ovf8; sbq.push_back(e);
    endtask

    // Present one character for exactly one clock edge, then check.
    task automatic send(input logic [7:0] c);
        logic [7:0] d;
        d = c - 8'h30;
        @(negedge clk);
        char_valid       = 1'b1;
        digit_valid      = (c >= 8'h30) && (c <= 8'h39);
        digit_in         = digit_valid ? d[3:0] : 4'd0;
        line_feed        = (c == 8'h0A);
        end_of_puzzle_tx = (c == 8'h04);
        @(posedge clk);
        #1;
        char_valid       = 1'b0;
        digit_valid      = 1'b0;
        digit_in         = 4'd0;
        line_feed        = 1'b0;
        end_of_puzzle_tx = 1'b0;
        check_sb();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(8'(s[i]));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        check_sb();
    endtask

    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] SP  = 8'h20;

    initial begin
        rst_n = 1'b0; char_valid = 1'b0; digit_in = 4'd0;
        digit_valid = 1'b0; line_feed = 1'b0; end_of_puzzle_tx = 1'b0;
        #12;
        expect3("reset", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        check_sb();
        @(negedge clk);
        rst_n = 1'b1;

        // Four example banks; 8-bit instance wraps on the third line.
        send_str("987654321111111");
        expect3("t1 line1", 64'd98, 16'd1, 64'd987654321111, 16'd1, 64'd98, 16'd1, 1'b0, 1'b0);
        send(LF);
        send_str("811111111111119");
        expect3("t1 line2", 64'd187, 16'd2, 64'd1798765432230, 16'd2, 64'd187, 16'd2, 1'b0, 1'b0);
        send(LF);
        send_str("234234234234278");
        expect3("t1 line3", 64'd265, 16'd3, 64'd2232999666508, 16'd3, 64'd9, 16'd3, 1'b0, 1'b1);
        send(LF);
        send_str("818181911112111");
        expect3("t1 line4", 64'd357, 16'd4, 64'd3121910778619, 16'd4, 64'd101, 16'd4, 1'b0, 1'b1);
        send(LF);
        expect3("t1 eot", 64'd357, 16'd4, 64'd3121910778619, 16'd4, 64'd101, 16'd4, 1'b1, 1'b1);
        send(EOT);

        // DONE ignores LF, EOT and idle cycles.
        expect3("done lf", 64'd357, 16'd4, 64'd3121910778619, 16'd4, 64'd101, 16'd4, 1'b1, 1'b1);
        send(LF);
        expect3("done eot", 64'd357, 16'd4, 64'd3121910778619, 16'd4, 64'd101, 16'd4, 1'b1, 1'b1);
        send(EOT);
        expect3("done idle", 64'd357, 16'd4, 64'd3121910778619, 16'd4, 64'd101, 16'd4, 1'b1, 1'b1);
        idle(3);

        // New puzzle: first digit clears sum, count, overflow and valid.
        expect3("t5 start", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        send("9");
        send("9");
        expect3("t5 line1", 64'd99, 16'd1, 64'd0, 16'd0, 64'd99, 16'd1, 1'b0, 1'b0);
        send(LF);
        send_str("99");
        expect3("t5 line2", 64'd198, 16'd2, 64'd0, 16'd0, 64'd198, 16'd2, 1'b0, 1'b0);
        send(LF);
        send_str("99");
        expect3("t5 line3", 64'd297, 16'd3, 64'd0, 16'd0, 64'd41, 16'd3, 1'b0, 1'b1);
        send(LF);
        expect3("t5 eot", 64'd297, 16'd3, 64'd0, 16'd0, 64'd41, 16'd3, 1'b1, 1'b1);
        send(EOT);

        // Short line, empty line, pending line folded by EOT.
        expect3("t3 start", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        send("9");
        expect3("t3 short", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        send(LF);
        expect3("t3 empty", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        send(LF);
        send_str("55");
        expect3("t3 eot", 64'd55, 16'd1, 64'd0, 16'd0, 64'd55, 16'd1, 1'b1, 1'b0);
        send(EOT);

        // CR, space and idle cycles inside a line are ignored.
        expect3("t4 start", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        send("9");
        expect3("t4 cr", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        send(CR);
        send(SP);
        idle(3);
        send("8");
        expect3("t4 line", 64'd98, 16'd1, 64'd0, 16'd0, 64'd98, 16'd1, 1'b0, 1'b0);
        send(LF);
        expect3("t4 eot", 64'd98, 16'd1, 64'd0, 16'd0, 64'd98, 16'd1, 1'b1, 1'b0);
        send(EOT);

        // Reset mid-line discards the pending "98".
        send_str("98");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect3("t6 in reset", 64'd0, 16'd0, 64'd0, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0);
        check_sb();
        @(negedge clk);
        rst_n = 1'b1;
        send_str("12");
        expect3("t6 line", 64'd12, 16'd1, 64'd0, 16'd0, 64'd12, 16'd1, 1'b0, 1'b0);
        send(LF);
        expect3("t6 eot", 64'd12, 16'd1, 64'd0, 16'd0, 64'd12, 16'd1, 1'b1, 1'b0);
        send(EOT);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
